// File: rtl/pe_pkg.sv
// Shared pixel/triple widths, tap slice positions and line-fill state
// encoding for the line buffer feeding the 3-tap pe.
package pe_pkg;
    localparam int PIX_W    = 8;
    localparam int TRIPLE_W = 3 * PIX_W;

    localparam int TAP_OLD_HI = 23;
    localparam int TAP_OLD_LO = 16;
    localparam int TAP_MID_HI = 15;
    localparam int TAP_MID_LO = 8;
    localparam int TAP_NEW_HI = 7;
    localparam int TAP_NEW_LO = 0;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } lb_row_e;
endpackage

// File: rtl/lb_line_mem.sv
// One image line of pixel storage: single address, combinational read of the
// old contents, write of the new contents on the same edge (read-first).
module lb_line_mem
    import pe_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem_q [IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/pe_line_buffer.sv
// Raster-to-column line buffer: emits {row y-2, row y-1, row y} per accepted pixel.
// Build option: define LB_TOP_PAD_EN to emit zero-padded triples for the first two lines.
module pe_line_buffer
    import pe_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    s_data,
    input  logic                s_valid,
    input  logic                s_sof,
    output logic                s_ready,
    output logic [TRIPLE_W-1:0] p,
    output logic                p_valid,
    output logic [COL_W-1:0]    p_col,
    output logic                p_eol
);
    logic                rst_q;
    logic [COL_W-1:0]    col_q, col_d;
    lb_row_e             row_q, row_d;
    logic [TRIPLE_W-1:0] p_q, p_d;
    logic                p_valid_q, p_valid_d;
    logic [COL_W-1:0]    p_col_q, p_col_d;
    logic                p_eol_q, p_eol_d;

    logic                accept;
    logic [COL_W-1:0]    col_cur;
    lb_row_e             row_cur;
    logic                last_col;
    logic [PIX_W-1:0]    tap_a, tap_b;

    assign s_ready = !rst_q;
    assign accept  = s_valid & s_ready;

    // SOF overrides the counters for the pixel it arrives with
    assign col_cur  = s_sof ? '0 : col_q;
    assign row_cur  = s_sof ? FILL0 : row_q;
    assign last_col = (col_cur == COL_W'(IMG_W - 1));

    lb_line_mem #(.IMG_W(IMG_W), .COL_W(COL_W)) u_lm1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cur),
        .wdata (s_data),
        .rdata (tap_a)
    );

    lb_line_mem #(.IMG_W(IMG_W), .COL_W(COL_W)) u_lm2 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cur),
        .wdata (tap_a),
        .rdata (tap_b)
    );

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        p_d       = p_q;
        p_valid_d = 1'b0;
        p_col_d   = p_col_q;
        p_eol_d   = p_eol_q;
        if (accept) begin
            col_d = last_col ? '0 : col_cur + 1'b1;
            row_d = row_cur;
            if (last_col) begin
                case (row_cur)
                    FILL0:   row_d = FILL1;
                    default: row_d = RUN;
                endcase
            end
            p_col_d = col_cur;
            p_eol_d = last_col;
            p_d[TAP_NEW_HI:TAP_NEW_LO] = s_data;
            p_d[TAP_MID_HI:TAP_MID_LO] = tap_a;
            p_d[TAP_OLD_HI:TAP_OLD_LO] = tap_b;
`ifdef LB_TOP_PAD_EN
            // Mask by fill state only; stale memory from a prior frame must not leak
            if (row_cur != RUN) begin
                p_d[TAP_OLD_HI:TAP_OLD_LO] = '0;
            end
            if (row_cur == FILL0) begin
                p_d[TAP_MID_HI:TAP_MID_LO] = '0;
            end
            p_valid_d = 1'b1;
`else
            p_valid_d = (row_cur == RUN);
`endif
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            col_q     <= '0;
            row_q     <= FILL0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_col_q   <= '0;
            p_eol_q   <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            p_col_q   <= p_col_d;
            p_eol_q   <= p_eol_d;
        end
    end

    assign p       = p_q;
    assign p_valid = p_valid_q;
    assign p_col   = p_col_q;
    assign p_eol   = p_eol_q;
endmodule

// File: tb/tb_pe_line_buffer.sv
// Directed bench for pe_line_buffer with IMG_W = 4 (honours LB_TOP_PAD_EN).
module tb_pe_line_buffer;
    import pe_pkg::*;

    localparam int IMG_W = 4;
    localparam int COL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_sof;
    logic             s_ready;
    logic [23:0]      p;
    logic             p_valid;
    logic [COL_W-1:0] p_col;
    logic             p_eol;

    int errors = 0;
    int checks = 0;

    pe_line_buffer #(.IMG_W(IMG_W), .COL_W(COL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_sof   (s_sof),
        .s_ready (s_ready),
        .p       (p),
        .p_valid (p_valid),
        .p_col   (p_col),
        .p_eol   (p_eol)
    );

    always #5 clk = ~clk;

    task automatic drive_pix(input logic [7:0] d, input logic sof);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (p !== 24'h0) begin errors++; $display("FAIL reset_p got=%h exp=000000", p); end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid got=%b exp=0", p_valid); end
        checks++; if (p_col !== 2'd0) begin errors++; $display("FAIL reset_p_col got=%0d exp=0", p_col); end
        checks++; if (p_eol !== 1'b0) begin errors++; $display("FAIL reset_p_eol got=%b exp=0", p_eol); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL release_s_ready got=%b exp=0", s_ready); end
        @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got=%b exp=1", s_ready); end
    endtask

    task automatic test_frame;
        logic [23:0] exp_pad [8] = '{24'h000001, 24'h000002, 24'h000003, 24'h000004,
                                     24'h000105, 24'h000206, 24'h000307, 24'h000408};
        logic [23:0] exp_run [4] = '{24'h010509, 24'h02060A, 24'h03070B, 24'h04080C};
        logic exp_v;
        for (int i = 0; i < 12; i++) begin
            drive_pix(8'(i + 1), i == 0);
`ifdef LB_TOP_PAD_EN
            exp_v = 1'b1;
`else
            exp_v = (i >= 8);
`endif
            checks++; if (p_valid !== exp_v) begin errors++; $display("FAIL frame_valid pix=%0d got=%b exp=%b", i + 1, p_valid, exp_v); end
            if (i >= 8) begin
                checks++; if (p !== exp_run[i-8]) begin errors++; $display("FAIL frame_p pix=%0d got=%h exp=%h", i + 1, p, exp_run[i-8]); end
                checks++; if (p_col !== 2'(i - 8)) begin errors++; $display("FAIL frame_col pix=%0d got=%0d exp=%0d", i + 1, p_col, i - 8); end
                checks++; if (p_eol !== (i == 11)) begin errors++; $display("FAIL frame_eol pix=%0d got=%b exp=%b", i + 1, p_eol, i == 11); end
            end
`ifdef LB_TOP_PAD_EN
            else begin
                checks++; if (p !== exp_pad[i]) begin errors++; $display("FAIL pad_p pix=%0d got=%h exp=%h", i + 1, p, exp_pad[i]); end
            end
`endif
        end
    endtask

    task automatic test_fourth_line;
        logic [23:0] exp_run [4] = '{24'h05090D, 24'h060A0E, 24'h070B0F, 24'h080C10};
        for (int i = 0; i < 4; i++) begin
            drive_pix(8'(13 + i), 1'b0);
            checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL line4_valid col=%0d got=%b exp=1", i, p_valid); end
            checks++; if (p !== exp_run[i]) begin errors++; $display("FAIL line4_p col=%0d got=%h exp=%h", i, p, exp_run[i]); end
            checks++; if (p_col !== 2'(i)) begin errors++; $display("FAIL line4_col got=%0d exp=%0d", p_col, i); end
        end
        idle_cycle();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL line4_drop got=%b exp=0", p_valid); end
    endtask

    task automatic test_gaps;
        logic exp_v;
        for (int i = 0; i < 12; i++) begin
            drive_pix(8'(i + 1), i == 0);
`ifdef LB_TOP_PAD_EN
            exp_v = 1'b1;
`else
            exp_v = (i >= 8);
`endif
            checks++; if (p_valid !== exp_v) begin errors++; $display("FAIL gap_valid pix=%0d got=%b exp=%b", i + 1, p_valid, exp_v); end
            if (i >= 8) begin
                checks++; if (p !== {8'(i - 7), 8'(i - 3), 8'(i + 1)}) begin errors++; $display("FAIL gap_p pix=%0d got=%h exp=%h", i + 1, p, {8'(i - 7), 8'(i - 3), 8'(i + 1)}); end
                checks++; if (p_col !== 2'(i - 8)) begin errors++; $display("FAIL gap_col pix=%0d got=%0d exp=%0d", i + 1, p_col, i - 8); end
            end
            if (i == 9) begin
                for (int g = 0; g < 3; g++) begin
                    idle_cycle();
                    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL gap_idle cyc=%0d got=%b exp=0", g, p_valid); end
                end
            end
        end
    endtask

    task automatic test_mid_sof;
        logic exp_v;
        drive_pix(8'd13, 1'b0);
        checks++; if (p !== 24'h05090D || p_valid !== 1'b1) begin errors++; $display("FAIL pre_sof0 got=%h/%b exp=05090d/1", p, p_valid); end
        drive_pix(8'd14, 1'b0);
        checks++; if (p !== 24'h060A0E || p_valid !== 1'b1) begin errors++; $display("FAIL pre_sof1 got=%h/%b exp=060a0e/1", p, p_valid); end
        for (int i = 0; i < 12; i++) begin
            drive_pix(8'(8'h21 + i), i == 0);
`ifdef LB_TOP_PAD_EN
            exp_v = 1'b1;
`else
            exp_v = (i >= 8);
`endif
            checks++; if (p_valid !== exp_v) begin errors++; $display("FAIL midsof_valid pix=%0d got=%b exp=%b", i, p_valid, exp_v); end
            if (i >= 8) begin
                checks++; if (p !== {8'(8'h19 + i), 8'(8'h1D + i), 8'(8'h21 + i)}) begin errors++; $display("FAIL midsof_p pix=%0d got=%h exp=%h", i, p, {8'(8'h19 + i), 8'(8'h1D + i), 8'(8'h21 + i)}); end
                checks++; if (p_col !== 2'(i - 8)) begin errors++; $display("FAIL midsof_col pix=%0d got=%0d exp=%0d", i, p_col, i - 8); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic exp_v;
        drive_pix(8'h2D, 1'b0);
        checks++; if (p !== 24'h25292D || p_valid !== 1'b1) begin errors++; $display("FAIL run_before_rst got=%h/%b exp=25292d/1", p, p_valid); end
        drive_pix(8'h2E, 1'b0);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", p_valid); end
        checks++; if (p !== 24'h0) begin errors++; $display("FAIL rstmid_p got=%h exp=000000", p); end
        checks++; if (p_col !== 2'd0 || p_eol !== 1'b0) begin errors++; $display("FAIL rstmid_col_eol got=%0d/%b exp=0/0", p_col, p_eol); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b exp=0", s_ready); end
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_release_ready got=%b exp=0", s_ready); end
        @(posedge clk);
        #1;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_accept got=%b exp=0", p_valid); end
        for (int i = 0; i < 12; i++) begin
            drive_pix(8'(8'h31 + i), 1'b0);
`ifdef LB_TOP_PAD_EN
            exp_v = 1'b1;
`else
            exp_v = (i >= 8);
`endif
            checks++; if (p_valid !== exp_v) begin errors++; $display("FAIL refill_valid pix=%0d got=%b exp=%b", i, p_valid, exp_v); end
            if (i >= 8) begin
                checks++; if (p !== {8'(8'h29 + i), 8'(8'h2D + i), 8'(8'h31 + i)}) begin errors++; $display("FAIL refill_p pix=%0d got=%h exp=%h", i, p, {8'(8'h29 + i), 8'(8'h2D + i), 8'(8'h31 + i)}); end
                checks++; if (p_col !== 2'(i - 8)) begin errors++; $display("FAIL refill_col pix=%0d got=%0d exp=%0d", i, p_col, i - 8); end
            end
        end
    endtask

    task automatic test_sof_last_col;
        logic exp_v;
        for (int i = 0; i < 3; i++) begin
            drive_pix(8'(8'h3D + i), 1'b0);
            checks++; if (p !== {8'(8'h35 + i), 8'(8'h39 + i), 8'(8'h3D + i)} || p_valid !== 1'b1) begin errors++; $display("FAIL pre_eol_sof col=%0d got=%h/%b", i, p, p_valid); end
        end
        for (int i = 0; i < 12; i++) begin
            drive_pix(8'(8'h41 + i), i == 0);
`ifdef LB_TOP_PAD_EN
            exp_v = 1'b1;
`else
            exp_v = (i >= 8);
`endif
            checks++; if (p_valid !== exp_v) begin errors++; $display("FAIL eolsof_valid pix=%0d got=%b exp=%b", i, p_valid, exp_v); end
            if (i == 0) begin
                checks++; if (p_col !== 2'd0 || p_eol !== 1'b0) begin errors++; $display("FAIL eolsof_first col/eol got=%0d/%b exp=0/0", p_col, p_eol); end
            end
            if (i >= 8) begin
                checks++; if (p !== {8'(8'h39 + i), 8'(8'h3D + i), 8'(8'h41 + i)}) begin errors++; $display("FAIL eolsof_p pix=%0d got=%h exp=%h", i, p, {8'(8'h39 + i), 8'(8'h3D + i), 8'(8'h41 + i)}); end
                checks++; if (p_eol !== (i == 11)) begin errors++; $display("FAIL eolsof_eol pix=%0d got=%b exp=%b", i, p_eol, i == 11); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_frame();
        test_fourth_line();
        test_gaps();
        test_mid_sof();
        test_reset_mid();
        test_sof_last_col();
        idle_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_line_buffer.md
# pe_line_buffer

Raster-to-column line buffer that feeds the 3-tap `pe`. It accepts an 8-bit unsigned pixel stream from the DMA read path, stores the two previous image lines, and emits one 24-bit vertical triple per accepted pixel on `p`/`p_valid`. Those ports connect directly to `pe.p`/`pe.p_valid`. There is no downstream backpressure, because `pe` accepts every cycle.

## Interface
- `IMG_W`, 64: pixels per line; must be ≥ 2.
- `COL_W`, `$clog2(IMG_W)`: column index width (derived).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  8  pixel, unsigned.
- `s_valid`  in  1  pixel present.
- `s_sof`  in  1  start of frame; qualified by `s_valid`.
- `s_ready`  out  1  pixel accepted when `s_valid & s_ready`.
- `p`  out  24  {row y-2, row y-1, row y}, each 8 bits, same column.
- `p_valid`  out  1  `p` is valid for exactly this cycle.
- `p_col`  out  COL_W  column index of `p`.
- `p_eol`  out  1  `p` is the last column of its line.

## Operation
- `s_ready` = `!rst_q`: it is 0 during the first cycle after reset release and 1 thereafter.
- Accept = `s_valid & s_ready`. Accepts are the only events that advance state.
- Column counter `col` counts 0..IMG_W-1 and wraps to 0. On the wrap, row counter `row` increments and saturates at 2.
- Line memories `lm1` (row y-1) and `lm2` (row y-2) are IMG_W×8, addressed by `col`, with read-first semantics. On each accept:
  - read `a = lm1[col]` and `b = lm2[col]`;
  - write `lm2[col] <= a` and `lm1[col] <= s_data`.
- Output register on accept: `p <= {b, a, s_data}`, `p_col <= col`, `p_eol <= (col == IMG_W-1)`.
- `p_valid` is set on accept when `row == 2`. The padding macro changes this rule (see Configuration).
- When `s_sof` is set with accept, the pixel is treated as `col = 0`, `row = 0`, regardless of the counter state. The counters then continue from `col = 1`. An SOF arriving mid-line abandons the partial line. Memory contents are not cleared.
- States, derived from `row`:
  - FILL0 (`row = 0`) → FILL1 on a line wrap.
  - FILL1 (`row = 1`) → RUN on a line wrap.
  - RUN (`row = 2`) stays in RUN.
  - SOF sends any state back to FILL0.
- A `s_valid` gap holds all state; `p_valid` drops to 0 on the next cycle.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N produces `p`/`p_valid` after edge N, so they are visible in cycle N+1.
- Throughput is 1 pixel/cycle sustained, including across line wraps.
- Reset values: `p = 0`, `p_valid = 0`, `p_col = 0`, `p_eol = 0`, `s_ready = 0`, `col = 0`, `row = 0`.
- Reset mid-line: all counters and outputs go to their reset values on the next edge. Any in-flight `p_valid` is dropped. The next accepted pixel is treated as row 0, col 0, even without SOF.
- Simultaneous SOF and the last column: SOF wins, and the wrap is not counted.
- `pe` adds one more cycle, so pixel-to-`o_valid` latency is 2 cycles.

## Configuration
- `LB_TOP_PAD_EN` defined:
  - `p_valid` is set on every accept, from row 0 onward.
  - Taps from lines not yet filled are forced to 0: in FILL0 `p = {0, 0, s_data}`; in FILL1 `p = {0, a, s_data}`.
  - Masking is driven by `row`, never by memory contents.
- `LB_TOP_PAD_EN` undefined: the first two lines of each frame produce no output.

## Structure
- Package `pe_pkg` holds:
  - `PIX_W = 8` and `TRIPLE_W = 3*PIX_W`;
  - tap slice constants `TAP_OLD = [23:16]`, `TAP_MID = [15:8]`, `TAP_NEW = [7:0]`;
  - the enum `lb_row_e {FILL0, FILL1, RUN}`.
- Sub-module `lb_line_mem`: single-port, read-first, IMG_W×PIX_W, with one read and one write at the same address per cycle. It is instantiated twice, for `lm1` and `lm2`.

## Test plan
Use IMG_W = 4 for all scenarios.
- **Three-line frame, no pad:** stream rows 1,2,3,4 / 5,6,7,8 / 9,10,11,12 with SOF on pixel 1.
  - Required: no output for the first 8 pixels.
  - Then `p` = 0x010509, 0x02060A, 0x03070B, 0x04080C with `p_col` 0..3, `p_eol` on the last, each 1 cycle after its accept.
- **Fourth line:** continue with 13..16.
  - Required: `p` = 0x05090D … 0x080C10. This confirms the line rotation.
- **Gaps:** drop `s_valid` for 3 cycles between pixels 10 and 11.
  - Required: `p_valid` is 0 for those 3 cycles; the values are the same as without gaps.
- **Mid-line SOF:** assert SOF at col 2 of line 3, then send 3 full lines.
  - Required: no output until the 3rd new line; the outputs then use only new-frame data.
- **Reset mid-frame:** assert `rst` in RUN.
  - Required: all outputs 0 on the next edge; `s_ready` = 0 for one cycle after release; a refill of 2 lines is needed before the next output.
- **`LB_TOP_PAD_EN`:** repeat the first scenario.
  - Required: outputs from the first pixel: 0x000001 … 0x000004, then 0x000105 … 0x000408, then 0x010509 ….
